mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 5: number of cycles the memory bus is held per access; legal range 1..15.
REQ-002 Parameter MEM_ADDR_W, default 16: width of the word address driven to memory.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 if_req  input  1  fetch request from the IF stage; held until if_ready or flush.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_rdata  output  32  fetched instruction; valid in the if_ready cycle.
REQ-008 if_ready  output  1  one-cycle pulse marking fetch completion.
REQ-009 dm_rd_en, dm_wr_en  input  1 each  MEM-stage load/store request; held until dm_ready.
REQ-010 dm_addr  input  32  data byte address.
REQ-011 dm_wdata  input  32  store data.
REQ-012 dm_rdata  output  32  load data; valid in the dm_ready cycle.
REQ-013 dm_ready  output  1  one-cycle pulse marking data-access completion.
REQ-014 freeze  output  1  pipeline stall to the IF/ID/EXE/MEM registers.
REQ-015 bus_addr  output  MEM_ADDR_W  word address, equal to byte address bits [MEM_ADDR_W+1:2].
REQ-016 bus_wdata  output  32; bus_we  output  1; bus_en  output  1; bus_rdata  input  32.

Function
REQ-017 FSM states: IDLE, ACCESS, DONE.
REQ-018 IDLE: pending data request -> grant DM, go ACCESS; else if_req -> grant IF, go ACCESS; else stay.
REQ-019 Simultaneous IF and DM requests: DM wins; IF is granted in the IDLE cycle following DM's DONE.
REQ-020 Grant, address, write data and write enable are registered at entry to ACCESS and held stable throughout ACCESS.
REQ-021 ACCESS: bus_en=1; bus_we=1 only for a DM write; counter runs 0..WAIT_CYCLES-1; at WAIT_CYCLES-1 bus_rdata is captured and the FSM goes to DONE.
REQ-022 DONE: exactly one cycle; pulse the granted ready; return to IDLE; bus_en=0.
REQ-023 Latency: request seen in IDLE at cycle N -> ready at cycle N+WAIT_CYCLES+1; back-to-back accesses are separated by one IDLE cycle.
REQ-024 dm_rd_en and dm_wr_en both high: treated as a write.
REQ-025 if_req dropped during an IF access (branch flush): access completes, if_ready is suppressed, and if_rdata is unchanged.
REQ-026 if_rdata and dm_rdata hold their last captured value until the next completing access of the same kind.
REQ-027 Writes leave dm_rdata unchanged.
REQ-028 freeze = (dm request pending and not dm_ready) or (if_req pending and not if_ready); combinational from registered state and inputs.
REQ-029 Address bits outside [MEM_ADDR_W+1:2] are ignored; no error signalling.

Reset
REQ-030 rst low: FSM to IDLE, counter 0, grant cleared; bus_en, bus_we, if_ready, dm_ready, if_rdata and dm_rdata all 0.
REQ-031 Reset mid-access aborts the access with no ready pulse; after release, the first edge samples requests afresh.

Structure
REQ-032 Shared package arm_pkg: FSM state enum, grant encoding (GNT_IF, GNT_DM), default WAIT_CYCLES.
REQ-033 One sub-module, wait_counter (load/enable, terminal-count output), is instantiated once.

Verification
REQ-034 if_req with if_addr=0x0000_0010, bus_rdata=0xE3A0_1005, WAIT_CYCLES=5 -> bus_addr=0x0004, if_ready at cycle 6, if_rdata=0xE3A0_1005, freeze high for cycles 0-5.
REQ-035 dm_wr_en with dm_addr=0x400, dm_wdata=0xDEAD_BEEF -> bus_we=1 for 5 cycles with bus_addr=0x0100 and bus_wdata=0xDEAD_BEEF; dm_ready at cycle 6; dm_rdata unchanged.
REQ-036 if_req and dm_rd_en asserted together -> DM served first (dm_ready at cycle 6), IF served next (if_ready at cycle 13).
REQ-037 if_req dropped at cycle 3 of a fetch -> access runs to DONE, no if_ready pulse, freeze low from cycle 3.
REQ-038 rst low at cycle 2 of an access -> all outputs 0 immediately, no ready pulse; a new request after release completes with normal latency.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared types and constants for the memory arbiter: FSM states, grant
// encoding and the default bus hold time.
package arm_pkg;

    localparam int DEFAULT_WAIT_CYCLES = 5;
    localparam int CNT_W               = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_DM   = 2'd2
    } grant_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side (IF/MEM) and memory-side signals of the arbiter, bundled.
// slave is the arbiter's view; master is the pipeline + memory model's view.
interface mem_arbiter_if #(
    parameter int MEM_ADDR_W = 16
) ();
    logic                  if_req;
    logic [31:0]           if_addr;
    logic [31:0]           if_rdata;
    logic                  if_ready;

    logic                  dm_rd_en;
    logic                  dm_wr_en;
    logic [31:0]           dm_addr;
    logic [31:0]           dm_wdata;
    logic [31:0]           dm_rdata;
    logic                  dm_ready;

    logic                  freeze;

    logic [MEM_ADDR_W-1:0] bus_addr;
    logic [31:0]           bus_wdata;
    logic                  bus_we;
    logic                  bus_en;
    logic [31:0]           bus_rdata;

    modport slave (
        input  if_req, if_addr, dm_rd_en, dm_wr_en, dm_addr, dm_wdata, bus_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready, freeze,
               bus_addr, bus_wdata, bus_we, bus_en
    );

    modport master (
        output if_req, if_addr, dm_rd_en, dm_wr_en, dm_addr, dm_wdata, bus_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready, freeze,
               bus_addr, bus_wdata, bus_we, bus_en
    );
endinterface

// File: rtl/mem_arbiter_wait_counter.sv
// Access-length counter: cleared by load, counts 0..WAIT_CYCLES-1 while
// enabled and holds at the terminal count.
module wait_counter
    import arm_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == CNT_W'(WAIT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data wins ties; every access holds the bus for WAIT_CYCLES then pulses ready.
module mem_arbiter
    import arm_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int MEM_ADDR_W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  arb
);

    state_e                state_q, state_d;
    grant_e                grant_q, grant_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  flush_q, flush_d;
    logic [31:0]           if_rdata_q, if_rdata_d;
    logic [31:0]           dm_rdata_q, dm_rdata_d;

    logic cnt_load;
    logic cnt_en;
    logic cnt_tc;
    logic dm_req;
    logic if_ready_s;
    logic dm_ready_s;

    assign dm_req = arb.dm_rd_en | arb.dm_wr_en;

    wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .tc_o   (cnt_tc)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        flush_d    = flush_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (dm_req) begin
                    grant_d  = GNT_DM;
                    addr_d   = arb.dm_addr[MEM_ADDR_W+1:2];
                    wdata_d  = arb.dm_wdata;
                    we_d     = arb.dm_wr_en;
                    flush_d  = 1'b0;
                    cnt_load = 1'b1;
                    state_d  = ST_ACCESS;
                end else if (arb.if_req) begin
                    grant_d  = GNT_IF;
                    addr_d   = arb.if_addr[MEM_ADDR_W+1:2];
                    wdata_d  = '0;
                    we_d     = 1'b0;
                    flush_d  = 1'b0;
                    cnt_load = 1'b1;
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_en = 1'b1;
                // A dropped fetch request is a branch flush; remember it so the
                // late result is discarded even if the request reappears.
                if (grant_q == GNT_IF && !arb.if_req) begin
                    flush_d = 1'b1;
                end
                if (cnt_tc) begin
                    state_d = ST_DONE;
                    if (grant_q == GNT_DM && !we_q) begin
                        dm_rdata_d = arb.bus_rdata;
                    end
                    if (grant_q == GNT_IF && arb.if_req && !flush_q) begin
                        if_rdata_d = arb.bus_rdata;
                    end
                end
            end
            ST_DONE: begin
                grant_d = GNT_NONE;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= GNT_NONE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            flush_q    <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            flush_q    <= flush_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign if_ready_s = (state_q == ST_DONE) && (grant_q == GNT_IF) && !flush_q && arb.if_req;
    assign dm_ready_s = (state_q == ST_DONE) && (grant_q == GNT_DM);

    assign arb.if_ready  = if_ready_s;
    assign arb.dm_ready  = dm_ready_s;
    assign arb.if_rdata  = if_rdata_q;
    assign arb.dm_rdata  = dm_rdata_q;
    assign arb.bus_en    = (state_q == ST_ACCESS);
    assign arb.bus_we    = (state_q == ST_ACCESS) && we_q;
    assign arb.bus_addr  = addr_q;
    assign arb.bus_wdata = wdata_q;

    // Gated by reset so every output reads 0 while reset is held.
    assign arb.freeze = rst_n && ((dm_req && !dm_ready_s) || (arb.if_req && !if_ready_s));

    logic unused_addr_bits;
    assign unused_addr_bits = ^{arb.if_addr[31:MEM_ADDR_W+2], arb.if_addr[1:0],
                                arb.dm_addr[31:MEM_ADDR_W+2], arb.dm_addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (WAIT_CYCLES=5, MEM_ADDR_W=16).
// Cycle 0 is the IDLE cycle in which a request is first presented.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.MEM_ADDR_W(16)) arb ();

    mem_arbiter #(
        .WAIT_CYCLES (5),
        .MEM_ADDR_W  (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (arb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (arb.bus_en !== 1'b0) begin n_fail++; $display("FAIL reset_bus_en: got %b want 0", arb.bus_en); end
        n_checks++; if (arb.bus_we !== 1'b0) begin n_fail++; $display("FAIL reset_bus_we: got %b want 0", arb.bus_we); end
        n_checks++; if (arb.if_ready !== 1'b0) begin n_fail++; $display("FAIL reset_if_ready: got %b want 0", arb.if_ready); end
        n_checks++; if (arb.dm_ready !== 1'b0) begin n_fail++; $display("FAIL reset_dm_ready: got %b want 0", arb.dm_ready); end
        n_checks++; if (arb.if_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_if_rdata: got %h want 0", arb.if_rdata); end
        n_checks++; if (arb.dm_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_dm_rdata: got %h want 0", arb.dm_rdata); end
        n_checks++; if (arb.freeze !== 1'b0) begin n_fail++; $display("FAIL reset_freeze: got %b want 0", arb.freeze); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (arb.bus_en !== 1'b0) begin n_fail++; $display("FAIL idle_bus_en: got %b want 0", arb.bus_en); end
        $display("reset: outputs checked in and after reset");
    endtask

    task automatic test_fetch();
        logic exp_en, exp_rdy, exp_frz;
        tick();
        arb.if_req = 1'b1; arb.if_addr = 32'h0000_0010; arb.bus_rdata = 32'hBAD0_0000;
        #1;
        n_checks++; if (arb.freeze !== 1'b1) begin n_fail++; $display("FAIL fetch_freeze c0: got %b want 1", arb.freeze); end
        n_checks++; if (arb.bus_en !== 1'b0) begin n_fail++; $display("FAIL fetch_bus_en c0: got %b want 0", arb.bus_en); end
        for (int c = 1; c <= 6; c++) begin
            tick();
            arb.bus_rdata = (c == 5) ? 32'hE3A0_1005 : (32'hBAD0_0000 + c);
            #1;
            exp_en = (c <= 5); exp_rdy = (c == 6); exp_frz = (c <= 5);
            n_checks++; if (arb.bus_en !== exp_en) begin n_fail++; $display("FAIL fetch_bus_en c%0d: got %b want %b", c, arb.bus_en, exp_en); end
            n_checks++; if (arb.if_ready !== exp_rdy) begin n_fail++; $display("FAIL fetch_if_ready c%0d: got %b want %b", c, arb.if_ready, exp_rdy); end
            n_checks++; if (arb.freeze !== exp_frz) begin n_fail++; $display("FAIL fetch_freeze c%0d: got %b want %b", c, arb.freeze, exp_frz); end
            if (c <= 5) begin
                n_checks++; if (arb.bus_addr !== 16'h0004) begin n_fail++; $display("FAIL fetch_bus_addr c%0d: got %h want 0004", c, arb.bus_addr); end
                n_checks++; if (arb.bus_we !== 1'b0) begin n_fail++; $display("FAIL fetch_bus_we c%0d: got %b want 0", c, arb.bus_we); end
            end
        end
        n_checks++; if (arb.if_rdata !== 32'hE3A0_1005) begin n_fail++; $display("FAIL fetch_if_rdata: got %h want e3a01005", arb.if_rdata); end
        tick();
        arb.if_req = 1'b0;
        #1;
        n_checks++; if (arb.if_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_ready_pulse c7: got %b want 0", arb.if_ready); end
        n_checks++; if (arb.bus_en !== 1'b0) begin n_fail++; $display("FAIL fetch_idle_bus_en c7: got %b want 0", arb.bus_en); end
        $display("fetch: addr=00000010 rdata=%h", arb.if_rdata);
    endtask

    task automatic test_priority();
        logic exp_en;
        tick();
        arb.if_req = 1'b1; arb.if_addr = 32'h0000_0020;
        arb.dm_rd_en = 1'b1; arb.dm_addr = 32'h0000_0800; arb.bus_rdata = 32'h0;
        #1;
        n_checks++; if (arb.freeze !== 1'b1) begin n_fail++; $display("FAIL prio_freeze c0: got %b want 1", arb.freeze); end
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 7) arb.dm_rd_en = 1'b0;
            arb.bus_rdata = (c == 5) ? 32'hCAFE_F00D : (c == 12) ? 32'h1111_2222 : (32'h5A5A_0000 + c);
            #1;
            exp_en = (c <= 5) || (c >= 8 && c <= 12);
            n_checks++; if (arb.bus_en !== exp_en) begin n_fail++; $display("FAIL prio_bus_en c%0d: got %b want %b", c, arb.bus_en, exp_en); end
            n_checks++; if (arb.dm_ready !== (c == 6)) begin n_fail++; $display("FAIL prio_dm_ready c%0d: got %b want %b", c, arb.dm_ready, (c == 6)); end
            n_checks++; if (arb.if_ready !== (c == 13)) begin n_fail++; $display("FAIL prio_if_ready c%0d: got %b want %b", c, arb.if_ready, (c == 13)); end
            if (c == 1) begin
                n_checks++; if (arb.bus_addr !== 16'h0200) begin n_fail++; $display("FAIL prio_dm_addr: got %h want 0200", arb.bus_addr); end
            end
            if (c == 8) begin
                n_checks++; if (arb.bus_addr !== 16'h0008) begin n_fail++; $display("FAIL prio_if_addr: got %h want 0008", arb.bus_addr); end
            end
            if (c == 6) begin
                n_checks++; if (arb.dm_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL prio_dm_rdata: got %h want cafef00d", arb.dm_rdata); end
                n_checks++; if (arb.freeze !== 1'b1) begin n_fail++; $display("FAIL prio_freeze c6: got %b want 1", arb.freeze); end
            end
        end
        n_checks++; if (arb.if_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL prio_if_rdata: got %h want 11112222", arb.if_rdata); end
        n_checks++; if (arb.dm_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL prio_dm_rdata_hold: got %h want cafef00d", arb.dm_rdata); end
        tick();
        arb.if_req = 1'b0;
        $display("priority: dm rdata=%h, if rdata=%h", arb.dm_rdata, arb.if_rdata);
    endtask

    task automatic test_write(input logic both, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [15:0] exp_addr);
        tick();
        arb.dm_wr_en = 1'b1; arb.dm_rd_en = both; arb.dm_addr = addr; arb.dm_wdata = wdata;
        arb.bus_rdata = 32'h5555_5555;
        for (int c = 1; c <= 6; c++) begin
            tick();
            n_checks++; if (arb.bus_we !== (c <= 5)) begin n_fail++; $display("FAIL wr_bus_we c%0d: got %b want %b", c, arb.bus_we, (c <= 5)); end
            n_checks++; if (arb.dm_ready !== (c == 6)) begin n_fail++; $display("FAIL wr_dm_ready c%0d: got %b want %b", c, arb.dm_ready, (c == 6)); end
            if (c <= 5) begin
                n_checks++; if (arb.bus_addr !== exp_addr) begin n_fail++; $display("FAIL wr_bus_addr c%0d: got %h want %h", c, arb.bus_addr, exp_addr); end
                n_checks++; if (arb.bus_wdata !== wdata) begin n_fail++; $display("FAIL wr_bus_wdata c%0d: got %h want %h", c, arb.bus_wdata, wdata); end
            end
        end
        n_checks++; if (arb.dm_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL wr_dm_rdata_hold: got %h want cafef00d", arb.dm_rdata); end
        tick();
        arb.dm_wr_en = 1'b0; arb.dm_rd_en = 1'b0;
        $display("write: addr=%h wdata=%h rd_also=%b", addr, wdata, both);
    endtask

    task automatic test_flush();
        tick();
        arb.if_req = 1'b1; arb.if_addr = 32'h0000_0040; arb.bus_rdata = 32'h7777_7777;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 3) arb.if_req = 1'b0;
            #1;
            n_checks++; if (arb.bus_en !== (c <= 5)) begin n_fail++; $display("FAIL flush_bus_en c%0d: got %b want %b", c, arb.bus_en, (c <= 5)); end
            n_checks++; if (arb.if_ready !== 1'b0) begin n_fail++; $display("FAIL flush_if_ready c%0d: got %b want 0", c, arb.if_ready); end
            n_checks++; if (arb.freeze !== (c < 3)) begin n_fail++; $display("FAIL flush_freeze c%0d: got %b want %b", c, arb.freeze, (c < 3)); end
            if (c == 1) begin
                n_checks++; if (arb.bus_addr !== 16'h0010) begin n_fail++; $display("FAIL flush_bus_addr: got %h want 0010", arb.bus_addr); end
            end
        end
        n_checks++; if (arb.if_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL flush_if_rdata: got %h want 11112222", arb.if_rdata); end
        $display("flush: fetch at 00000040 dropped, if_rdata=%h", arb.if_rdata);
    endtask

    task automatic test_reset_mid_access();
        tick();
        arb.if_req = 1'b1; arb.if_addr = 32'h0000_0080; arb.bus_rdata = 32'h9ABC_DEF0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if (arb.bus_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_bus_en: got %b want 0", arb.bus_en); end
        n_checks++; if (arb.if_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_if_rdata: got %h want 0", arb.if_rdata); end
        n_checks++; if (arb.dm_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_dm_rdata: got %h want 0", arb.dm_rdata); end
        n_checks++; if (arb.freeze !== 1'b0) begin n_fail++; $display("FAIL rstmid_freeze: got %b want 0", arb.freeze); end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++; if (arb.if_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_if_ready r%0d: got %b want 0", c, arb.if_ready); end
        end
        rst_n = 1'b1;
        #1;
        n_checks++; if (arb.freeze !== 1'b1) begin n_fail++; $display("FAIL rstmid_freeze_rel: got %b want 1", arb.freeze); end
        for (int c = 1; c <= 6; c++) begin
            tick();
            n_checks++; if (arb.bus_en !== (c <= 5)) begin n_fail++; $display("FAIL rstmid_bus_en c%0d: got %b want %b", c, arb.bus_en, (c <= 5)); end
            n_checks++; if (arb.if_ready !== (c == 6)) begin n_fail++; $display("FAIL rstmid_if_ready c%0d: got %b want %b", c, arb.if_ready, (c == 6)); end
            if (c == 1) begin
                n_checks++; if (arb.bus_addr !== 16'h0020) begin n_fail++; $display("FAIL rstmid_bus_addr: got %h want 0020", arb.bus_addr); end
            end
        end
        n_checks++; if (arb.if_rdata !== 32'h9ABC_DEF0) begin n_fail++; $display("FAIL rstmid_if_rdata_new: got %h want 9abcdef0", arb.if_rdata); end
        tick();
        arb.if_req = 1'b0;
        $display("reset mid-access: aborted, refetch rdata=%h", arb.if_rdata);
    endtask

    initial begin
        rst_n        = 1'b0;
        arb.if_req   = 1'b0;
        arb.if_addr  = 32'h0;
        arb.dm_rd_en = 1'b0;
        arb.dm_wr_en = 1'b0;
        arb.dm_addr  = 32'h0;
        arb.dm_wdata = 32'h0;
        arb.bus_rdata = 32'h0;

        test_reset();
        test_fetch();
        test_priority();
        test_write(1'b0, 32'h0000_0400, 32'hDEAD_BEEF, 16'h0100);
        test_write(1'b1, 32'hABCD_0407, 32'h0BAD_C0DE, 16'h4101);
        test_flush();
        test_reset_mid_access();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
